// File: rtl/split_track.sv
// Split-transaction tracker: routes one master request to one of N slaves by address.
// Optional watchdog on stalled slaves enabled by defining SPLIT_TIMEOUT_EN.
module split_track #(
  parameter int N_SLAVES = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SEL_W    = $clog2(N_SLAVES),
  parameter int TIMEOUT  = 255,
  localparam int REQ_W   = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int RESP_W  = DATA_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_W-1:0]             m_req,
  output logic [RESP_W-1:0]            m_resp,
  output logic                         m_err,
  output logic [N_SLAVES*REQ_W-1:0]    s_req,
  input  logic [N_SLAVES*RESP_W-1:0]   s_resp,
  output logic                         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  localparam logic [SEL_W:0] NS = (SEL_W + 1)'(N_SLAVES);

  logic [1:0]          state;
  logic [1:0]          nxt;
  logic [SEL_W-1:0]    sel;
  logic [SEL_W-1:0]    sel_q;
  logic                req_v;
  logic                in_range;
  logic [RESP_W-1:0]   resp_sel;
  logic [RESP_W-1:0]   resp_q;
  logic [N_SLAVES-1:0] s_v;

  assign req_v    = m_req[REQ_W-1];
  assign sel      = m_req[REQ_W-2 -: SEL_W];
  assign in_range = {1'b0, sel} < NS;
  assign resp_sel = s_resp[sel*RESP_W +: RESP_W];
  assign resp_q   = s_resp[sel_q*RESP_W +: RESP_W];
  assign busy     = (state != IDLE);

`ifdef SPLIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
  logic             expired;

  assign expired = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end
`else
  logic expired;
  assign expired = 1'b0;
`endif

  always_comb begin
    nxt    = state;
    m_resp = '0;
    m_err  = 1'b0;
    s_v    = '0;
    case (state)
      IDLE: begin
        if (req_v) begin
          if (in_range) begin
            s_v[sel] = 1'b1;
            m_resp   = resp_sel;
            if (!resp_sel[0]) nxt = BUSY;
          end else begin
            nxt = ERR;
          end
        end
      end
      BUSY: begin
        m_resp = resp_q;
        if (resp_q[0]) begin
          nxt = IDLE;
        end else if (expired) begin
          nxt = ERR;
        end
      end
      ERR: begin
        m_resp = {{DATA_W{1'b0}}, 1'b1};
        m_err  = 1'b1;
        nxt    = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // non-selected slices still see the request payload, only valid is gated
  for (genvar k = 0; k < N_SLAVES; k++) begin : g_slv
    assign s_req[k*REQ_W +: REQ_W] = {s_v[k], m_req[REQ_W-2:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == BUSY) sel_q <= sel;
    end
  end

endmodule

// File: tb/tb_split_track.sv
// Directed bench for split_track: a 4-slave and a 3-slave instance.
module tb_split_track;

  localparam int REQ_W  = 69;
  localparam int RESP_W = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [REQ_W-1:0]    req4, req3;
  logic [RESP_W-1:0]   resp4, resp3;
  logic                err4, err3, busy4, busy3;
  logic [4*REQ_W-1:0]  sq4;
  logic [3*REQ_W-1:0]  sq3;
  logic [4*RESP_W-1:0] sr4;
  logic [3*RESP_W-1:0] sr3;
  logic [3:0]          rdy4;
  logic [2:0]          rdy3;
  logic [31:0]         rd4 [4];
  logic [31:0]         rd3 [3];
  logic [3:0]          vm4;
  logic [2:0]          vm3;

  split_track #(.N_SLAVES(4), .TIMEOUT(8)) u4 (
    .clk(clk), .rst(rst), .m_req(req4), .m_resp(resp4), .m_err(err4),
    .s_req(sq4), .s_resp(sr4), .busy(busy4)
  );

  split_track #(.N_SLAVES(3)) u3 (
    .clk(clk), .rst(rst), .m_req(req3), .m_resp(resp3), .m_err(err3),
    .s_req(sq3), .s_resp(sr3), .busy(busy3)
  );

  always_comb begin
    sr4 = '0;
    vm4 = '0;
    for (int k = 0; k < 4; k++) begin
      sr4[k*RESP_W +: RESP_W] = {rd4[k], rdy4[k]};
      vm4[k] = sq4[k*REQ_W + REQ_W - 1];
    end
  end

  always_comb begin
    sr3 = '0;
    vm3 = '0;
    for (int k = 0; k < 3; k++) begin
      sr3[k*RESP_W +: RESP_W] = {rd3[k], rdy3[k]};
      vm3[k] = sq3[k*REQ_W + REQ_W - 1];
    end
  end

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [REQ_W-1:0] mk(input logic v,
                                          input logic [1:0] s);
    logic [31:0] a;
    a = {s, 30'h1234};
    return {v, a, a ^ 32'h5555_0000, 4'hF};
  endfunction

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [3:0]  rdy;
    logic [31:0] base;
    logic        e_rdy;
    logic [31:0] e_rd;
    logic [3:0]  e_vm;
  } vec_t;

  vec_t tv [6];

  initial begin
    tv[0] = '{1'b0, 2'd2, 4'b1111, 32'h1000_0000, 1'b0, 32'h0, 4'b0000};
    tv[1] = '{1'b1, 2'd2, 4'b0100, 32'hCAFE_F00B, 1'b1, 32'hCAFE_F00D, 4'b0100};
    tv[2] = '{1'b1, 2'd0, 4'b0001, 32'h2000_0000, 1'b1, 32'h2000_0000, 4'b0001};
    tv[3] = '{1'b1, 2'd3, 4'b1111, 32'h3000_0000, 1'b1, 32'h3000_0003, 4'b1000};
    tv[4] = '{1'b1, 2'd1, 4'b1010, 32'h4000_0000, 1'b1, 32'h4000_0001, 4'b0010};
    tv[5] = '{1'b0, 2'd1, 4'b0010, 32'h5000_0000, 1'b0, 32'h0, 4'b0000};

    req4 = '0;
    req3 = '0;
    rdy4 = '0;
    rdy3 = '0;
    for (int k = 0; k < 4; k++) rd4[k] = 32'hDEAD_0000 + k;
    for (int k = 0; k < 3; k++) rd3[k] = 32'hBEEF_0000 + k;

    // reset state
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_resp4", 96'(resp4), 96'(0));
    chk("rst_err4", 96'(err4), 96'(0));
    chk("rst_busy4", 96'(busy4), 96'(0));
    chk("rst_vm4", 96'(vm4), 96'(0));
    chk("rst_busy3", 96'(busy3), 96'(0));

    // zero-latency / idle table
    for (int i = 0; i < 6; i++) begin
      step();
      req4 = mk(tv[i].v, tv[i].sel);
      rdy4 = tv[i].rdy;
      for (int k = 0; k < 4; k++) rd4[k] = tv[i].base + 32'(k);
      #1;
      chk($sformatf("tv%0d_rdy", i), 96'(resp4[0]), 96'(tv[i].e_rdy));
      chk($sformatf("tv%0d_rdata", i), 96'(resp4[32:1]), 96'(tv[i].e_rd));
      chk($sformatf("tv%0d_err", i), 96'(err4), 96'(0));
      chk($sformatf("tv%0d_vm", i), 96'(vm4), 96'(tv[i].e_vm));
      chk($sformatf("tv%0d_mirror", i), 96'(sq4[3*REQ_W +: REQ_W-1]),
          96'(mk(1'b0, tv[i].sel)));
      step();
      req4 = '0;
      rdy4 = '0;
      #1;
      chk($sformatf("tv%0d_busy", i), 96'(busy4), 96'(0));
    end

    // split transaction to slave 1, stray ready from slave 3
    step();
    req4 = mk(1'b1, 2'd1);
    #1;
    chk("sp_vm0", 96'(vm4), 96'(4'b0010));
    chk("sp_rdy0", 96'(resp4[0]), 96'(0));
    step();
    req4 = '0;
    rdy4 = 4'b1000;
    #1;
    chk("sp_busy1", 96'(busy4), 96'(1));
    chk("sp_rdy1", 96'(resp4[0]), 96'(0));
    step();
    rdy4 = '0;
    req4 = mk(1'b1, 2'd0);
    #1;
    chk("sp_busy2", 96'(busy4), 96'(1));
    chk("sp_ignore_vm", 96'(vm4), 96'(0));
    step();
    req4 = '0;
    rdy4 = 4'b0010;
    rd4[1] = 32'h1234_5678;
    #1;
    chk("sp_busy3", 96'(busy4), 96'(1));
    chk("sp_rdy3", 96'(resp4[0]), 96'(1));
    chk("sp_rd3", 96'(resp4[32:1]), 96'(32'h1234_5678));
    chk("sp_err3", 96'(err4), 96'(0));
    step();
    rdy4 = '0;
    #1;
    chk("sp_busy4", 96'(busy4), 96'(0));

    // out-of-range select on 3-slave instance
    step();
    req3 = {1'b1, 32'hC000_0000, 32'h0, 4'hF};
    #1;
    chk("oor_vm", 96'(vm3), 96'(0));
    chk("oor_rdy0", 96'(resp3[0]), 96'(0));
    step();
    req3 = '0;
    rdy3 = 3'b111;
    #1;
    chk("oor_resp", 96'(resp3), 96'({32'h0, 1'b1}));
    chk("oor_err", 96'(err3), 96'(1));
    chk("oor_busy", 96'(busy3), 96'(1));
    step();
    rdy3 = '0;
    #1;
    chk("oor_idle", 96'(busy3), 96'(0));
    chk("oor_resp_idle", 96'(resp3), 96'(0));

    // reset while busy abandons the transaction
    step();
    req4 = mk(1'b1, 2'd1);
    step();
    req4 = '0;
    #1;
    chk("rb_busy", 96'(busy4), 96'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    rdy4 = 4'b0010;
    #1;
    chk("rb_busy_after", 96'(busy4), 96'(0));
    chk("rb_late_rdy", 96'(resp4[0]), 96'(0));
    step();
    rdy4 = 4'b0001;
    rd4[0] = 32'hA5A5_0001;
    req4 = mk(1'b1, 2'd0);
    #1;
    chk("rb_next_rdy", 96'(resp4[0]), 96'(1));
    chk("rb_next_rd", 96'(resp4[32:1]), 96'(32'hA5A5_0001));
    step();
    req4 = '0;
    rdy4 = '0;

    // back-to-back
    step();
    req4 = mk(1'b1, 2'd0);
    step();
    req4 = '0;
    step();
    rdy4 = 4'b0001;
    rd4[0] = 32'h0000_B2B0;
    #1;
    chk("bb_rdy0", 96'(resp4[0]), 96'(1));
    chk("bb_rd0", 96'(resp4[32:1]), 96'(32'h0000_B2B0));
    step();
    rdy4 = 4'b0010;
    rd4[1] = 32'h0000_B2B1;
    req4 = mk(1'b1, 2'd1);
    #1;
    chk("bb_vm1", 96'(vm4), 96'(4'b0010));
    chk("bb_rd1", 96'(resp4), 96'({32'h0000_B2B1, 1'b1}));
    step();
    req4 = '0;
    rdy4 = '0;
    #1;
    chk("bb_busy", 96'(busy4), 96'(0));

    // stalled slave 0
    step();
    req4 = mk(1'b1, 2'd0);
    step();
    req4 = '0;
`ifdef SPLIT_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk($sformatf("to_wait%0d", c), 96'({busy4, resp4[0]}), 96'(2'b10));
      step();
    end
    #1;
    chk("to_resp", 96'(resp4), 96'({32'h0, 1'b1}));
    chk("to_err", 96'(err4), 96'(1));
    step();
    step();
    step();
    rdy4 = 4'b0001;
    #1;
    chk("to_late", 96'({busy4, resp4[0]}), 96'(2'b00));
    step();
    rdy4 = '0;
`else
    for (int c = 1; c <= 12; c++) begin
      #1;
      chk($sformatf("nt_wait%0d", c), 96'({busy4, resp4[0]}), 96'(2'b10));
      step();
    end
    rdy4 = 4'b0001;
    #1;
    chk("nt_done", 96'({resp4[0], err4}), 96'(2'b10));
    step();
    rdy4 = '0;
    #1;
    chk("nt_idle", 96'(busy4), 96'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
